// File: rtl/apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: controller state encoding and
// the AHB HTRANS codes used by the slave interface.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_controller.sv
// APB sequencing half of the AHB-to-APB bridge: turns qualified AHB transfers
// into APB SETUP/ACCESS phases and stretches HREADYOUT while they complete.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              VALID,
    input  logic              TEMP_SELX,
    input  logic              HWRITE,
    input  logic              HWRITE_REG,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [ADDR_W-1:0] HADDR_1,
    input  logic [ADDR_W-1:0] HADDR_2,
    input  logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HWDATA_1,
    input  logic [DATA_W-1:0] PRDATA,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              HREADYOUT,
    output logic [DATA_W-1:0] HRDATA
);

    state_e              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                hready_q, hready_d;
    logic                v;

    assign v = VALID & TEMP_SELX;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                if (!v)          state_d = ST_IDLE;
                else if (HWRITE) state_d = ST_WWAIT;
                else             state_d = ST_READ;
            end
            ST_WWAIT:  state_d = v ? ST_WRITEP : ST_WRITE;
            ST_READ:   state_d = ST_RENABLE;
            ST_WRITE:  state_d = v ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP: state_d = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!HWRITE_REG) state_d = ST_READ;
                else if (!v)     state_d = ST_WRITE;
                else             state_d = ST_WRITEP;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are decided by the state being entered, so they register on the
    // same edge as the state itself.
    always_comb begin
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        hready_d  = hready_q;
        unique case (state_d)
            ST_READ: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                paddr_d   = HADDR;
                hready_d  = 1'b0;
            end
            ST_WRITE, ST_WRITEP: begin
                psel_d    = 1'b1;
                penable_d = 1'b0;
                pwrite_d  = 1'b1;
                // Chained writes come out of WENABLEP one pipeline stage later.
                if (state_q == ST_WENABLEP) begin
                    paddr_d  = HADDR_2;
                    pwdata_d = HWDATA_1;
                end else begin
                    paddr_d  = HADDR_1;
                    pwdata_d = HWDATA;
                end
                hready_d  = (state_d == ST_WRITE);
            end
            ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
                hready_d  = 1'b1;
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                hready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESET) begin
        if (!HRESET) begin
            state_q   <= ST_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            hready_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            hready_q  <= hready_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign HREADYOUT = hready_q;
    assign HRDATA    = PRDATA;

endmodule

// File: tb/tb_apb_controller.sv
// Directed bench for apb_controller: a per-cycle vector table of inputs and
// expected registered outputs, plus a hand-written asynchronous reset sequence.
module tb_apb_controller;

    logic        HCLK;
    logic        HRESET;
    logic        VALID;
    logic        TEMP_SELX;
    logic        HWRITE;
    logic        HWRITE_REG;
    logic [31:0] HADDR;
    logic [31:0] HADDR_1;
    logic [31:0] HADDR_2;
    logic [31:0] HWDATA;
    logic [31:0] HWDATA_1;
    logic [31:0] PRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        HREADYOUT;
    logic [31:0] HRDATA;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct {
        logic        v;
        logic        sel;
        logic        hw;
        logic        hwr;
        logic [31:0] a;
        logic [31:0] a1;
        logic [31:0] a2;
        logic [31:0] d;
        logic [31:0] d1;
        logic [31:0] pr;
        logic        ePsel;
        logic        ePen;
        logic        ePw;
        logic [31:0] ePaddr;
        logic [31:0] ePwdata;
        logic        eHro;
    } vec_t;

    vec_t vecs[$];

    apb_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .VALID      (VALID),
        .TEMP_SELX  (TEMP_SELX),
        .HWRITE     (HWRITE),
        .HWRITE_REG (HWRITE_REG),
        .HADDR      (HADDR),
        .HADDR_1    (HADDR_1),
        .HADDR_2    (HADDR_2),
        .HWDATA     (HWDATA),
        .HWDATA_1   (HWDATA_1),
        .PRDATA     (PRDATA),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .HREADYOUT  (HREADYOUT),
        .HRDATA     (HRDATA)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic v, input logic sel, input logic hw, input logic hwr,
                          input logic [31:0] a, input logic [31:0] a1, input logic [31:0] a2,
                          input logic [31:0] d, input logic [31:0] d1, input logic [31:0] pr,
                          input logic ePsel, input logic ePen, input logic ePw,
                          input logic [31:0] ePaddr, input logic [31:0] ePwdata, input logic eHro);
        vec_t t;
        t.v = v; t.sel = sel; t.hw = hw; t.hwr = hwr;
        t.a = a; t.a1 = a1; t.a2 = a2; t.d = d; t.d1 = d1; t.pr = pr;
        t.ePsel = ePsel; t.ePen = ePen; t.ePw = ePw;
        t.ePaddr = ePaddr; t.ePwdata = ePwdata; t.eHro = eHro;
        vecs.push_back(t);
    endtask

    task automatic applyStimulus(input vec_t t);
        VALID      = t.v;
        TEMP_SELX  = t.sel;
        HWRITE     = t.hw;
        HWRITE_REG = t.hwr;
        HADDR      = t.a;
        HADDR_1    = t.a1;
        HADDR_2    = t.a2;
        HWDATA     = t.d;
        HWDATA_1   = t.d1;
        PRDATA     = t.pr;
    endtask

    task automatic checkAll(input string tag, input logic ePsel, input logic ePen, input logic ePw,
                            input logic [31:0] ePaddr, input logic [31:0] ePwdata, input logic eHro);
        checkOutput({tag, " PSEL"},      {31'd0, PSEL},      {31'd0, ePsel});
        checkOutput({tag, " PENABLE"},   {31'd0, PENABLE},   {31'd0, ePen});
        checkOutput({tag, " PWRITE"},    {31'd0, PWRITE},    {31'd0, ePw});
        checkOutput({tag, " PADDR"},     PADDR,              ePaddr);
        checkOutput({tag, " PWDATA"},    PWDATA,             ePwdata);
        checkOutput({tag, " HREADYOUT"}, {31'd0, HREADYOUT}, {31'd0, eHro});
    endtask

    initial begin
        vec_t idleVec;
        idleVec = '{v: 1'b0, sel: 1'b1, hw: 1'b0, hwr: 1'b0, a: 32'd0, a1: 32'd0, a2: 32'd0,
                    d: 32'd0, d1: 32'd0, pr: 32'd0, ePsel: 1'b0, ePen: 1'b0, ePw: 1'b0,
                    ePaddr: 32'd0, ePwdata: 32'd0, eHro: 1'b1};

        // single read
        addVec(1,1,0,0, 32'h80000010, 0, 0, 0, 0, 0,            1,0,0, 32'h80000010, 32'h0, 0);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 32'hDEADBEEF,            1,1,0, 32'h80000010, 32'h0, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       0,0,0, 32'h80000010, 32'h0, 1);
        // single write
        addVec(1,1,1,0, 32'h80000020, 0, 0, 0, 0, 0,            0,0,0, 32'h80000010, 32'h0, 1);
        addVec(0,1,0,1, 0, 32'h80000020, 0, 32'h12345678, 0, 0, 1,0,1, 32'h80000020, 32'h12345678, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       1,1,1, 32'h80000020, 32'h12345678, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       0,0,1, 32'h80000020, 32'h12345678, 1);
        // three chained writes
        addVec(1,1,1,0, 32'h80000100, 0, 0, 0, 0, 0,            0,0,1, 32'h80000020, 32'h12345678, 1);
        addVec(1,1,1,1, 32'h80000104, 32'h80000100, 0, 32'hA0000000, 0, 0,
                                                                1,0,1, 32'h80000100, 32'hA0000000, 0);
        addVec(1,1,1,1, 32'h80000108, 32'h80000104, 32'h80000100, 32'hA1111111, 32'hA0000000, 0,
                                                                1,1,1, 32'h80000100, 32'hA0000000, 1);
        addVec(1,1,1,1, 32'h80000108, 32'h80000108, 32'h80000104, 32'hA2222222, 32'hA1111111, 0,
                                                                1,0,1, 32'h80000104, 32'hA1111111, 0);
        addVec(1,1,1,1, 32'h80000108, 32'h80000108, 32'h80000108, 32'hA2222222, 32'hA2222222, 0,
                                                                1,1,1, 32'h80000104, 32'hA1111111, 1);
        addVec(0,1,0,1, 0, 32'h8000FFFF, 32'h80000108, 32'hFFFFFFFF, 32'hA2222222, 0,
                                                                1,0,1, 32'h80000108, 32'hA2222222, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       1,1,1, 32'h80000108, 32'hA2222222, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       0,0,1, 32'h80000108, 32'hA2222222, 1);
        // write followed directly by read
        addVec(1,1,1,0, 32'h80000200, 0, 0, 0, 0, 0,            0,0,1, 32'h80000108, 32'hA2222222, 1);
        addVec(1,1,0,1, 32'h80000300, 32'h80000200, 0, 32'h55AA55AA, 0, 0,
                                                                1,0,1, 32'h80000200, 32'h55AA55AA, 0);
        addVec(1,1,0,0, 32'h80000300, 0, 0, 0, 0, 0,            1,1,1, 32'h80000200, 32'h55AA55AA, 1);
        addVec(1,1,0,0, 32'h80000300, 32'h80000300, 32'h80000200, 0, 32'h55AA55AA, 0,
                                                                1,0,0, 32'h80000300, 32'h55AA55AA, 0);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 32'hCAFEF00D,            1,1,0, 32'h80000300, 32'h55AA55AA, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       0,0,0, 32'h80000300, 32'h55AA55AA, 1);
        // VALID high but slave not selected
        for (int k = 0; k < 5; k++)
            addVec(1,0,k[0],k[0], 32'h80000900, 32'h80000900, 32'h80000900, 32'h99999999, 32'h99999999,
                   32'h13579BDF,                                0,0,0, 32'h80000300, 32'h55AA55AA, 1);
        // ENABLE states going straight into the next transfer
        addVec(1,1,0,0, 32'h80000400, 0, 0, 0, 0, 0,            1,0,0, 32'h80000400, 32'h55AA55AA, 0);
        addVec(1,1,1,0, 32'h80000500, 0, 0, 0, 0, 32'h0F0F0F0F, 1,1,0, 32'h80000400, 32'h55AA55AA, 1);
        addVec(1,1,1,0, 32'h80000500, 0, 0, 0, 0, 0,            0,0,0, 32'h80000400, 32'h55AA55AA, 1);
        addVec(0,1,0,1, 0, 32'h80000500, 0, 32'h0BADCAFE, 0, 0, 1,0,1, 32'h80000500, 32'h0BADCAFE, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       1,1,1, 32'h80000500, 32'h0BADCAFE, 1);
        addVec(1,1,0,0, 32'h80000600, 0, 0, 0, 0, 0,            1,0,0, 32'h80000600, 32'h0BADCAFE, 0);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 32'h2468ACE0,            1,1,0, 32'h80000600, 32'h0BADCAFE, 1);
        addVec(0,1,0,0, 0, 0, 0, 0, 0, 0,                       0,0,0, 32'h80000600, 32'h0BADCAFE, 1);

        HRESET = 1'b0;
        applyStimulus(idleVec);
        repeat (2) @(posedge HCLK);
        #1;
        checkAll("reset", 0, 0, 0, 32'h0, 32'h0, 1);
        @(negedge HCLK);
        HRESET = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            @(posedge HCLK);
            #1;
            checkAll($sformatf("row%0d", i), vecs[i].ePsel, vecs[i].ePen, vecs[i].ePw,
                     vecs[i].ePaddr, vecs[i].ePwdata, vecs[i].eHro);
            checkOutput($sformatf("row%0d HRDATA", i), HRDATA, vecs[i].pr);
        end

        // Reset asserted while a write SETUP is in progress
        applyStimulus(idleVec);
        VALID = 1'b1; HWRITE = 1'b1; HADDR = 32'h80000700;
        @(posedge HCLK);
        #1;
        VALID = 1'b0; HWRITE = 1'b0; HADDR_1 = 32'h80000700; HWDATA = 32'h77777777;
        @(posedge HCLK);
        #1;
        checkAll("preReset", 1, 0, 1, 32'h80000700, 32'h77777777, 1);
        #2;
        HRESET = 1'b0;
        #1;
        checkAll("asyncReset", 0, 0, 0, 32'h0, 32'h0, 1);
        @(negedge HCLK);
        HRESET = 1'b1;
        applyStimulus(idleVec);
        @(posedge HCLK);
        #1;
        checkAll("postReset", 0, 0, 0, 32'h0, 32'h0, 1);
        VALID = 1'b1; HADDR = 32'h80000800;
        @(posedge HCLK);
        #1;
        checkAll("postResetRead", 1, 0, 0, 32'h80000800, 32'h0, 0);
        applyStimulus(idleVec);
        @(posedge HCLK);
        #1;
        checkAll("postResetAccess", 1, 1, 0, 32'h80000800, 32'h0, 1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
